timer_controller: RTL
=====================

# timer_controller

Sequencing controller for the 8-bit counter/compare/event-flag timer datapath. It starts and stops counting and supports one-shot and periodic modes. It sets a sticky overflow flag when the count matches a latched compare value, and holds that flag until acknowledged. It also reports overrun when a periodic match occurs while the previous event is still unacknowledged. It sits between the processor-side control signals and the timer datapath.

## Interface
- WIDTH, 8: counter and compare width in bits.
- PRE_WIDTH, 8: prescaler width in bits. Used only with `TIMER_PRESCALER_EN`.

- iClk  input  1  system clock; all state changes on the rising edge.
- iReset  input  1  synchronous, active-low reset. Sampled on the rising edge of iClk; 0 resets the block.
- iStart  input  1  start request, level-sampled each cycle; acted on only in IDLE.
- iStop  input  1  stop request; aborts RUN or DONE and returns to IDLE.
- iMode  input  1  0 = one-shot, 1 = periodic; latched at start.
- iCompare  input  WIDTH  terminal count C; latched at start.
- iPrescale  input  PRE_WIDTH  prescale value P; latched at start.
- iAck  input  1  clears oTimerOverflow and oMissed.
- oCount  output  WIDTH  current count.
- oTimerOverflow  output  1  sticky event flag.
- oMissed  output  1  sticky overrun flag.
- oBusy  output  1  1 while in RUN.
- oState  output  2  IDLE = 00, RUN = 01, DONE = 10; 11 is never produced.

## Operation
- **Reset** (iReset = 0 at an edge): state goes to IDLE. oCount, oTimerOverflow, oMissed, oBusy, the latched compare/mode/prescale values and the prescaler counter all go to 0. Reset overrides every other input in any state.
- **IDLE**
  - Count holds 0.
  - iStart = 1 and iStop = 0: latch iCompare, iMode and iPrescale; clear the prescaler; go to RUN.
  - iStart and iStop both 1: stop wins and the state stays IDLE.
- **RUN**
  - On each tick, if oCount == C_latched, a match occurs. Otherwise oCount increments by 1.
  - The count range is 0..C and never wraps past C. C = 0 matches on every tick.
  - Match in periodic mode: oCount goes to 0 and the state stays RUN.
  - Match in one-shot mode: oCount holds C and the state goes to DONE.
  - iStop = 1: go to IDLE and clear oCount to 0. Flags are kept.
  - iStart is ignored in RUN.
- **DONE**
  - oCount holds C.
  - iAck = 1 or iStop = 1: go to IDLE and clear oCount to 0.
  - iStart is ignored in DONE.
- **oTimerOverflow**
  - Set on a match.
  - Cleared by iAck when no match occurs in the same cycle.
  - Match and iAck in the same cycle: the flag stays 1, so a new event is never lost.
- **oMissed**
  - Set on a match while oTimerOverflow is already 1 and iAck = 0.
  - Cleared by iAck under the same rule as oTimerOverflow.
- A change to iCompare, iMode or iPrescale while in RUN has no effect until the next start.

## Timing
- Start accepted at edge k: after edge k, oState = 01, oBusy = 1 and oCount = 0.
- Without prescaler: a tick occurs every cycle in RUN. The first increment is at edge k+1.
  - The first match sets oTimerOverflow at edge k+C+1.
  - In periodic mode, subsequent matches occur every C+1 cycles.
- With prescaler:
  - The prescaler counts 0..P and produces a tick when it equals P, then returns to 0.
  - The first tick is at edge k+P+1.
  - The first match is at edge k+(C+1)(P+1).
  - The period is (C+1)(P+1) cycles.
- All outputs are registered. A flag set at edge n is visible after edge n; iAck sampled at edge n clears it after edge n.
- One-shot: oBusy falls and oState = 10 on the same edge that oTimerOverflow rises.
- iStop at edge n: oState = 00 after edge n. The prescaler is cleared, so the phase never carries over into the next run.

## Configuration
- `TIMER_PRESCALER_EN` defined: the prescaler counter is compiled in, and iPrescale is latched and used as described in Timing.
- `TIMER_PRESCALER_EN` undefined:
  - No prescaler logic is built; a tick occurs every cycle in RUN.
  - iPrescale stays on the port list but is ignored; PRE_WIDTH is unused.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold iReset = 0 for 2 cycles mid-RUN with C = 5 → oState = 00, oCount = 0, all flags 0 after the first reset edge.
- **One-shot, no prescaler:** C = 3, iMode = 0, start at edge k → oCount 1, 2, 3 at edges k+1..k+3. At edge k+4, oTimerOverflow = 1 and oState = 10. iAck at edge k+6 → IDLE, flag 0.
- **Periodic overrun:**
  - C = 1, iMode = 1, no ack → flag set at edge k+2 and oMissed = 1 at edge k+4.
  - iAck coincident with the match at edge k+6 → both flags remain 1.
  - iAck at edge k+7 → both flags 0.
- **Prescaler** (`TIMER_PRESCALER_EN`): C = 2, P = 3, periodic → matches at edges k+12, k+24 and k+36; oCount steps every 4 cycles.
- **Stop/start precedence:**
  - iStart and iStop together in IDLE → stays IDLE.
  - iStop at edge k+2 of a C = 9 run → oCount = 0, state IDLE, no flag.
  - iStart during RUN → ignored.
- **Compare = 0:** C = 0, periodic, no prescaler → oTimerOverflow = 1 at edge k+1, oCount stays 0, and oMissed = 1 at edge k+2 without ack.

Source files
------------

// File: rtl/timer_controller.sv
// ---------------------------------------------------------------------------
// timer_controller
//
// Sequencing controller for an 8-bit counter/compare/event-flag timer.
// Starts and stops counting in one-shot or periodic mode. A match between the
// running count and the compare value latched at start raises a sticky event
// flag. A match that lands while the previous event is still unacknowledged
// also raises a sticky overrun flag.
//
// Optional feature macro: TIMER_PRESCALER_EN
//   defined   : a prescaler divides the count tick by (P+1), where P is the
//               iPrescale value latched at start.
//   undefined : the count ticks every cycle in RUN, and iPrescale is ignored.
//
// Parameters
//   WIDTH      counter / compare width
//   PRE_WIDTH  prescaler width (only meaningful with TIMER_PRESCALER_EN)
//
// Ports
//   iClk            system clock, rising-edge active
//   iReset          synchronous reset, active low
//   iStart          start request (acted on in IDLE only)
//   iStop           stop request (RUN/DONE -> IDLE; beats iStart in IDLE)
//   iMode           0 = one-shot, 1 = periodic (latched at start)
//   iCompare        terminal count C (latched at start)
//   iPrescale       prescale value P (latched at start)
//   iAck            acknowledge; clears both sticky flags
//   oCount          current count
//   oTimerOverflow  sticky event flag
//   oMissed         sticky overrun flag
//   oBusy           1 while in RUN
//   oState          IDLE = 00, RUN = 01, DONE = 10
// ---------------------------------------------------------------------------
module timer_controller #(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic                 iStop,
    input  logic                 iMode,
    input  logic [WIDTH-1:0]     iCompare,
    input  logic [PRE_WIDTH-1:0] iPrescale,
    input  logic                 iAck,
    output logic [WIDTH-1:0]     oCount,
    output logic                 oTimerOverflow,
    output logic                 oMissed,
    output logic                 oBusy,
    output logic [1:0]           oState
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   cmp_q,    cmp_d;
    logic               mode_q,   mode_d;
    logic               ovf_q,    ovf_d;
    logic               missed_q, missed_d;
    logic               busy_q,   busy_d;
    logic               tick;
    logic               match;

`ifdef TIMER_PRESCALER_EN
    localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

    logic [PRE_WIDTH-1:0] pre_val_q, pre_val_d;
    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
`else
    // Prescale input is kept on the port list for a uniform interface.
    logic unused_prescale;
    assign unused_prescale = ^iPrescale;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        cmp_d    = cmp_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;
        missed_d = missed_q;
        match    = 1'b0;
`ifdef TIMER_PRESCALER_EN
        pre_val_d = pre_val_q;
        pre_cnt_d = pre_cnt_q;
        // Prescaler runs 0..P; the tick fires on the cycle it sits at P.
        tick      = (pre_cnt_q == pre_val_q);
`else
        tick      = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                count_d = '0;
`ifdef TIMER_PRESCALER_EN
                pre_cnt_d = '0;
`endif
                // Stop beats start when both are asserted together.
                if (iStart && !iStop) begin
                    state_d = RUN;
                    cmp_d   = iCompare;
                    mode_d  = iMode;
`ifdef TIMER_PRESCALER_EN
                    pre_val_d = iPrescale;
`endif
                end
            end

            RUN: begin
                // Stop aborts the run outright; any match due this cycle
                // is discarded together with the run.
                if (iStop) begin
                    state_d = IDLE;
                    count_d = '0;
`ifdef TIMER_PRESCALER_EN
                    pre_cnt_d = '0;
`endif
                end else begin
`ifdef TIMER_PRESCALER_EN
                    pre_cnt_d = tick ? '0 : (pre_cnt_q + PRE_ONE);
`endif
                    if (tick) begin
                        // Count never passes C: reaching C is the match.
                        if (count_q == cmp_q) begin
                            match = 1'b1;
                            if (mode_q) begin
                                count_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end
            end

            DONE: begin
                if (iAck || iStop) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // A match in the same cycle as iAck wins so no event is lost.
        if (match) begin
            ovf_d = 1'b1;
            if (ovf_q && !iAck) begin
                missed_d = 1'b1;
            end
        end else if (iAck) begin
            ovf_d    = 1'b0;
            missed_d = 1'b0;
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cmp_q    <= '0;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef TIMER_PRESCALER_EN
            pre_val_q <= '0;
            pre_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
            busy_q   <= busy_d;
`ifdef TIMER_PRESCALER_EN
            pre_val_q <= pre_val_d;
            pre_cnt_q <= pre_cnt_d;
`endif
        end
    end

    assign oCount         = count_q;
    assign oTimerOverflow = ovf_q;
    assign oMissed        = missed_q;
    assign oBusy          = busy_q;
    assign oState         = state_q;

endmodule
